// File: rtl/cla_pkg.sv
// Shared constants and flag helper for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam int BLK_W_DEF = 16;
  localparam int GRP_W     = 4;

  // Signed mode flags carry-in/out disagreement at the MSB; unsigned mode flags carry (add) or borrow (sub).
  function automatic logic ovfFlag(input logic sign, input logic sub,
                                   input logic cMsbIn, input logic cMsbOut);
    if (sign) return cMsbIn ^ cMsbOut;
    return sub ? ~cMsbOut : cMsbOut;
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLK_W-bit adder: 4-bit groups form group P/G, and every group
// carry and bit carry is a flat sum-of-products of the block carry-in.
module cla_block
  import cla_pkg::*;
#(
  parameter int BLK_W = BLK_W_DEF
) (
  input  logic [BLK_W-1:0] a,
  input  logic [BLK_W-1:0] b,
  input  logic             cin,
  output logic [BLK_W-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  localparam int NUM_GRP = BLK_W / GRP_W;

  logic [BLK_W-1:0]   w_g;
  logic [BLK_W-1:0]   w_p;
  logic [BLK_W-1:0]   w_c;
  logic [NUM_GRP-1:0] w_grpG;
  logic [NUM_GRP-1:0] w_grpP;
  logic [NUM_GRP:0]   w_grpC;
  logic               w_gTerm;
  logic               w_cTerm;
  logic               w_bTerm;

  assign w_g = a & b;
  assign w_p = a ^ b;

  always_comb begin
    w_grpG  = '0;
    w_grpP  = '0;
    w_gTerm = 1'b0;
    for (int j = 0; j < NUM_GRP; j++) begin
      w_grpP[j] = &w_p[j*GRP_W +: GRP_W];
      for (int i = 0; i < GRP_W; i++) begin
        w_gTerm = w_g[j*GRP_W+i];
        for (int m = i + 1; m < GRP_W; m++) w_gTerm = w_gTerm & w_p[j*GRP_W+m];
        w_grpG[j] = w_grpG[j] | w_gTerm;
      end
    end
  end

  // Group carry j: cin propagated through all lower groups, OR any lower group generating through the rest.
  always_comb begin
    w_grpC  = '0;
    w_cTerm = 1'b0;
    for (int j = 0; j <= NUM_GRP; j++) begin
      w_cTerm = cin;
      for (int m = 0; m < j; m++) w_cTerm = w_cTerm & w_grpP[m];
      w_grpC[j] = w_cTerm;
      for (int i = 0; i < j; i++) begin
        w_cTerm = w_grpG[i];
        for (int m = i + 1; m < j; m++) w_cTerm = w_cTerm & w_grpP[m];
        w_grpC[j] = w_grpC[j] | w_cTerm;
      end
    end
  end

  always_comb begin
    w_c     = '0;
    w_bTerm = 1'b0;
    for (int j = 0; j < NUM_GRP; j++) begin
      for (int i = 0; i < GRP_W; i++) begin
        w_bTerm = w_grpC[j];
        for (int m = 0; m < i; m++) w_bTerm = w_bTerm & w_p[j*GRP_W+m];
        w_c[j*GRP_W+i] = w_bTerm;
        for (int k = 0; k < i; k++) begin
          w_bTerm = w_g[j*GRP_W+k];
          for (int m = k + 1; m < i; m++) w_bTerm = w_bTerm & w_p[j*GRP_W+m];
          w_c[j*GRP_W+i] = w_c[j*GRP_W+i] | w_bTerm;
        end
      end
    end
  end

  assign sum      = w_p ^ w_c;
  assign cout     = w_grpC[NUM_GRP];
  assign c_msb_in = w_c[BLK_W-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined add/sub: one lookahead block per stage, inter-block carry registered,
// valid/ready handshake with a whole-pipe stall when the output is blocked.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLK_W = BLK_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NUM_BLK = WIDTH / BLK_W;

  logic             w_adv;
  logic [WIDTH-1:0] r_a     [NUM_BLK];
  logic [WIDTH-1:0] r_b     [NUM_BLK];
  logic [WIDTH-1:0] r_sum   [NUM_BLK];
  logic             r_valid [NUM_BLK];
  logic             r_carry [NUM_BLK];
  logic             r_sub   [NUM_BLK];
  logic             r_sign  [NUM_BLK];
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  logic [WIDTH-1:0] w_stA     [NUM_BLK];
  logic [WIDTH-1:0] w_stB     [NUM_BLK];
  logic [WIDTH-1:0] w_stSum   [NUM_BLK];
  logic [WIDTH-1:0] w_nxSum   [NUM_BLK];
  logic             w_stValid [NUM_BLK];
  logic             w_stCin   [NUM_BLK];
  logic             w_stSub   [NUM_BLK];
  logic             w_stSign  [NUM_BLK];
  logic [BLK_W-1:0] w_blkSum  [NUM_BLK];
  logic             w_blkCout [NUM_BLK];
  logic             w_blkCmsb [NUM_BLK];

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  // Stage 0 takes the ports (B inverted, Cin = sub); later stages take the previous stage registers.
  always_comb begin
    w_stValid[0] = in_valid;
    w_stA[0]     = a;
    w_stB[0]     = b ^ {WIDTH{sub}};
    w_stCin[0]   = sub;
    w_stSub[0]   = sub;
    w_stSign[0]  = sign;
    w_stSum[0]   = '0;
    for (int k = 1; k < NUM_BLK; k++) begin
      w_stValid[k] = r_valid[k-1];
      w_stA[k]     = r_a[k-1];
      w_stB[k]     = r_b[k-1];
      w_stCin[k]   = r_carry[k-1];
      w_stSub[k]   = r_sub[k-1];
      w_stSign[k]  = r_sign[k-1];
      w_stSum[k]   = r_sum[k-1];
    end
  end

  for (genvar k = 0; k < NUM_BLK; k++) begin : g_blk
    cla_block #(.BLK_W(BLK_W)) u_blk (
      .a        (w_stA[k][k*BLK_W +: BLK_W]),
      .b        (w_stB[k][k*BLK_W +: BLK_W]),
      .cin      (w_stCin[k]),
      .sum      (w_blkSum[k]),
      .cout     (w_blkCout[k]),
      .c_msb_in (w_blkCmsb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NUM_BLK; k++) begin
      w_nxSum[k]                   = w_stSum[k];
      w_nxSum[k][k*BLK_W +: BLK_W] = w_blkSum[k];
    end
  end

  // Data registers only load on a valid beat, so bubbles leave the last result on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_BLK; k++) begin
        r_valid[k] <= 1'b0;
        r_sum[k]   <= '0;
        r_carry[k] <= 1'b0;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < NUM_BLK; k++) begin
        r_valid[k] <= w_stValid[k];
        if (w_stValid[k]) begin
          r_sum[k]   <= w_nxSum[k];
          r_carry[k] <= w_blkCout[k];
          if (k < NUM_BLK - 1) begin
            r_a[k]    <= w_stA[k];
            r_b[k]    <= w_stB[k];
            r_sub[k]  <= w_stSub[k];
            r_sign[k] <= w_stSign[k];
          end
        end
      end
      if (w_stValid[NUM_BLK-1]) begin
        r_ovf  <= ovfFlag(w_stSign[NUM_BLK-1], w_stSub[NUM_BLK-1],
                          w_blkCmsb[NUM_BLK-1], w_blkCout[NUM_BLK-1]);
        r_zero <= (w_nxSum[NUM_BLK-1] == '0);
        r_neg  <= w_nxSum[NUM_BLK-1][WIDTH-1];
      end
    end
  end

  assign out_valid = r_valid[NUM_BLK-1];
  assign sum       = r_sum[NUM_BLK-1];
  assign cout      = r_carry[NUM_BLK-1];
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign neg       = r_neg;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe (32-bit, two 16-bit stages) with a result scoreboard.
module tb_cla_addsub_pipe;

  localparam int W   = 32;
  localparam int LAT = 2;

  typedef struct {
    logic [35:0] res;
    int          stamp;
    bit          lat;
  } sbEntry_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         sign;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         neg;

  int          passCnt  = 0;
  int          checkCnt = 0;
  int          cyc      = 0;
  bit          checkLat = 1'b0;
  bit          prevStall = 1'b0;
  logic [35:0] prevObs;
  logic [35:0] obs;
  sbEntry_t    sb[$];
  sbEntry_t    e;

  cla_addsub_pipe #(.WIDTH(W), .BLK_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .sign      (sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  // Reference: plain 33-bit arithmetic; signed overflow from operand/result sign bits.
  function automatic logic [35:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                        input logic ms, input logic mg);
    logic [W-1:0] bx;
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         c;
    logic         o;
    bx   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bx} + {{W{1'b0}}, ms};
    r    = full[W-1:0];
    c    = full[W];
    o    = mg ? ((ma[W-1] == bx[W-1]) && (r[W-1] != ma[W-1])) : (ms ? ~c : c);
    return {r, c, o, (r == '0), r[W-1]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCnt++;
    assert (observed === expected) passCnt++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic ts, input logic tg, input bit randReady);
    bit acc = 1'b0;
    int n   = 0;
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    sub      = ts;
    sign     = tg;
    while (!acc && n < 100) begin
      if (randReady) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = (in_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic directedStep(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                              input logic ts, input logic tg, input logic [W-1:0] xSum,
                              input logic xC, input logic xO, input logic xZ, input logic xN);
    int n = 0;
    applyStimulus(ta, tb, ts, tg, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (out_valid === 1'b1)
      checkOutput(tag, 64'({sum, cout, ovf, zero, neg}), 64'({xSum, xC, xO, xZ, xN}));
    else
      checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Scoreboard: push on acceptance, pop on transfer; reset flushes everything in flight.
  always @(negedge clk) begin
    cyc++;
    if (rst === 1'b1) begin
      sb.delete();
      prevStall = 1'b0;
    end else begin
      obs = {sum, cout, ovf, zero, neg};
      if (prevStall) checkOutput("stall_hold", 64'({out_valid, obs}), 64'({1'b1, prevObs}));
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out", 64'd0, 64'd1);
        end else begin
          e = sb.pop_front();
          checkOutput("result", 64'(obs), 64'(e.res));
          if (e.lat) checkOutput("latency", 64'(cyc - e.stamp), 64'(LAT));
        end
      end
      prevStall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prevObs   = obs;
      if (in_valid === 1'b1 && in_ready === 1'b1)
        sb.push_back('{model(a, b, sub, sign), cyc, checkLat});
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 32'd5;
    b         = 32'd3;
    sub       = 1'b0;
    sign      = 1'b0;
    out_ready = 1'b1;

    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset_outputs", 64'({out_valid, sum, cout, ovf, zero, neg}), 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    repeat (3) @(negedge clk);

    checkLat = 1'b1;
    directedStep("add_wrap",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
    directedStep("sadd_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1,
                 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    directedStep("ssub_ovf",      32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1,
                 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    directedStep("usub_borrow",   32'd5, 32'd7, 1'b1, 1'b0,
                 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1);
    directedStep("ssub_neg",      32'd5, 32'd7, 1'b1, 1'b1,
                 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    directedStep("blk_carry",     32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    directedStep("blk_carry_out", 32'h0000_FFFF, 32'hFFFF_0001, 1'b0, 1'b0,
                 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0);

    // Back-to-back at full rate, then a reset pulse with beats still in flight.
    for (int i = 0; i < 8; i++)
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    rst = 1'b1;
    a   = 32'h1234_5678;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_ready", 64'(in_ready), 64'd1);
    repeat (4) @(negedge clk);

    checkLat = 1'b0;
    for (int i = 0; i < 50; i++)
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
